// File: rtl/countdown_display_ctrl_pkg.sv
// Shared types and constants for the countdown timer with a two-digit
// multiplexed seven-segment display.
package countdown_display_ctrl_pkg;

    // Countdown controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Largest value the two-digit display can show
    localparam logic [6:0] MAX_COUNT = 7'd99;

    // All segments off
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Scan slot index values
    localparam logic DIGIT_ONES = 1'b0;
    localparam logic DIGIT_TENS = 1'b1;

    // Saturate a requested start value to what the display can show
    function automatic logic [6:0] clamp_count(input logic [6:0] value);
        return (value > MAX_COUNT) ? MAX_COUNT : value;
    endfunction

endpackage

// File: rtl/countdown_display_ctrl_bin_to_7seg.sv
// BCD digit to active-high seven-segment pattern (bit0=a ... bit6=g).
// Codes 10..15 never occur in this design and are mapped to dark.
module bin_to_7seg
    import countdown_display_ctrl_pkg::*;
(
    input  logic [3:0] bin,
    output logic [6:0] seg
);

    // Pure lookup of the segment pattern for one decimal digit
    always_comb begin
        seg = SEG_BLANK;
        case (bin)
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/countdown_display_ctrl.sv
// Seconds countdown (0..99) with pause, done pulse and a two-digit
// time-multiplexed seven-segment driver with leading-zero blanking.
// The display scan runs free and is independent of the countdown.
module countdown_display_ctrl
    import countdown_display_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [6:0] load_val,
    input  logic       pause,
    input  logic       blank,
    output logic [6:0] count,
    output logic       busy,
    output logic       done,
    output logic [6:0] seg,
    output logic [1:0] dig_sel
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    state_t            state_reg, state_next;
    logic [6:0]        count_reg;
    logic [TICK_W-1:0] tick_reg;
    logic              done_reg;
    logic [SCAN_W-1:0] scan_reg;
    logic              digit_idx_reg;
    logic [6:0]        seg_reg, seg_next;
    logic [1:0]        dig_sel_reg, dig_sel_next;

    logic              tick_wrap;
    logic              advance;
    logic [3:0]        tens_val, ones_val, dec_in;
    logic [6:0]        seg_dec;
    logic              digit_lit;

    assign tick_wrap = (tick_reg == TICK_LAST);
    // The tick counter only moves in RUN while pause stays low
    assign advance   = (state_reg == ST_RUN) && !pause;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; a load overrides both expiry and pause handling
    always_comb begin
        state_next = state_reg;
        if (load) begin
            if (load_val == 7'd0) begin
                state_next = ST_IDLE;
            end else if (pause) begin
                state_next = ST_HOLD;
            end else begin
                state_next = ST_RUN;
            end
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (pause) begin
                        state_next = ST_HOLD;
                    end else if (tick_wrap && count_reg == 7'd1) begin
                        state_next = ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (!pause) begin
                        state_next = ST_RUN;
                    end
                end
                default: state_next = state_reg;
            endcase
        end
    end

    // State-derived outputs
    always_comb begin
        busy = (state_reg != ST_IDLE);
    end

    // Countdown datapath: second tick divider, remaining count, done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= 7'd0;
            tick_reg  <= '0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (load) begin
                count_reg <= clamp_count(load_val);
                tick_reg  <= '0;
            end else if (advance) begin
                if (tick_wrap) begin
                    tick_reg  <= '0;
                    count_reg <= count_reg - 7'd1;
                    if (count_reg == 7'd1) begin
                        done_reg <= 1'b1;
                    end
                end else begin
                    tick_reg <= tick_reg + TICK_W'(1);
                end
            end
        end
    end

    // Free-running scan divider; flips the active digit at each wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_reg      <= '0;
            digit_idx_reg <= DIGIT_ONES;
        end else if (scan_reg == SCAN_LAST) begin
            scan_reg      <= '0;
            digit_idx_reg <= ~digit_idx_reg;
        end else begin
            scan_reg <= scan_reg + SCAN_W'(1);
        end
    end

    // Decimal split of the live count and selection of the scanned digit
    always_comb begin
        tens_val = 4'(count_reg / 7'd10);
        ones_val = 4'(count_reg % 7'd10);
        dec_in   = (digit_idx_reg == DIGIT_TENS) ? tens_val : ones_val;
    end

    bin_to_7seg u_dec (
        .bin (dec_in),
        .seg (seg_dec)
    );

    // A digit is lit unless blanked or it is a leading zero in the tens slot
    assign digit_lit = !blank && !((digit_idx_reg == DIGIT_TENS) && (tens_val == 4'd0));

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dig_sel
            assign dig_sel_next[gi] = digit_lit && (digit_idx_reg == 1'(gi));
        end
    endgenerate

    // Segment pattern for the current slot
    always_comb begin
        seg_next = digit_lit ? seg_dec : SEG_BLANK;
    end

    // Register the display drive so the pins are glitch-free
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_reg     <= SEG_BLANK;
            dig_sel_reg <= 2'b00;
        end else begin
            seg_reg     <= seg_next;
            dig_sel_reg <= dig_sel_next;
        end
    end

    assign count   = count_reg;
    assign done    = done_reg;
    assign seg     = seg_reg;
    assign dig_sel = dig_sel_reg;

endmodule

// File: tb/tb_countdown_display_ctrl.sv
// Bench for countdown_display_ctrl with short divider settings: a table of
// hand-derived vectors, directed multi-cycle sequences and a randomized run
// checked against a cycle-level behavioural model.
module tb_countdown_display_ctrl;

    localparam int TICK_DIV = 8;
    localparam int SCAN_DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [6:0] load_val;
    logic       pause;
    logic       blank;
    logic [6:0] count;
    logic       busy;
    logic       done;
    logic [6:0] seg;
    logic [1:0] dig_sel;

    always #5 clk = ~clk;

    countdown_display_ctrl #(
        .TICK_DIV (TICK_DIV),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .pause    (pause),
        .blank    (blank),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .seg      (seg),
        .dig_sel  (dig_sel)
    );

    int compared   = 0;
    int mismatched = 0;

    logic [6:0] seg_rom [0:9] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                                  7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                                  7'b1111111, 7'b1101111};

    // Behavioural model: remaining seconds, running-cycle phase within the
    // current second, and the cycle number since reset for the scan position.
    int         m_count, m_phase, m_edges;
    bit         m_active, m_lastp, m_done;
    logic [6:0] m_seg;
    logic [1:0] m_dsel;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_edge();
        int idx, tens, ones;
        if (rst) begin
            m_count = 0; m_phase = 0; m_edges = 0;
            m_active = 0; m_lastp = 0; m_done = 0;
            m_seg = 7'b0; m_dsel = 2'b00;
        end else begin
            idx  = (m_edges / SCAN_DIV) % 2;
            tens = m_count / 10;
            ones = m_count % 10;
            if (blank) begin
                m_seg = 7'b0; m_dsel = 2'b00;
            end else if (idx == 0) begin
                m_seg = seg_rom[ones]; m_dsel = 2'b01;
            end else if (tens == 0) begin
                m_seg = 7'b0; m_dsel = 2'b00;
            end else begin
                m_seg = seg_rom[tens]; m_dsel = 2'b10;
            end
            m_edges++;
            m_done = 0;
            if (load) begin
                m_count  = (load_val > 99) ? 99 : int'(load_val);
                m_phase  = 0;
                m_active = (m_count != 0);
                m_lastp  = pause;
            end else if (m_active) begin
                // A second elapses only on cycles where pause was low at this
                // edge and at the previous one.
                if (!m_lastp && !pause) begin
                    m_phase++;
                    if (m_phase == TICK_DIV) begin
                        m_phase = 0;
                        m_count--;
                        if (m_count == 0) begin
                            m_active = 0;
                            m_done   = 1;
                        end
                    end
                end
                m_lastp = pause;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".count"},   count,   m_count);
        check({tag, ".busy"},    busy,    m_active);
        check({tag, ".done"},    done,    m_done);
        check({tag, ".seg"},     seg,     m_seg);
        check({tag, ".dig_sel"}, dig_sel, m_dsel);
    endtask

    task automatic cycle(input string tag);
        step();
        check_model(tag);
    endtask

    typedef struct {
        logic       rst;
        logic       load;
        logic [6:0] lv;
        logic       pause;
        logic       blank;
        int         e_count;
        logic       e_busy;
        logic       e_done;
        logic [6:0] e_seg;
        logic [1:0] e_dsel;
    } vec_t;

    vec_t vecs [22];
    int   done_seen;

    initial begin
        rst = 1'b1; load = 1'b0; load_val = 7'd0; pause = 1'b0; blank = 1'b0;

        // rst load lv pause blank | count busy done seg dig_sel
        vecs[0]  = '{1'b1, 1'b0, 7'd0,   1'b0, 1'b0, 0,  1'b0, 1'b0, 7'b0000000, 2'b00};
        vecs[1]  = '{1'b0, 1'b0, 7'd0,   1'b0, 1'b0, 0,  1'b0, 1'b0, 7'b0111111, 2'b01};
        vecs[2]  = '{1'b0, 1'b0, 7'd0,   1'b1, 1'b0, 0,  1'b0, 1'b0, 7'b0111111, 2'b01};
        vecs[3]  = '{1'b0, 1'b0, 7'd0,   1'b0, 1'b0, 0,  1'b0, 1'b0, 7'b0111111, 2'b01};
        vecs[4]  = '{1'b0, 1'b0, 7'd0,   1'b0, 1'b0, 0,  1'b0, 1'b0, 7'b0111111, 2'b01};
        vecs[5]  = '{1'b0, 1'b0, 7'd0,   1'b0, 1'b0, 0,  1'b0, 1'b0, 7'b0000000, 2'b00};
        vecs[6]  = '{1'b0, 1'b0, 7'd0,   1'b0, 1'b0, 0,  1'b0, 1'b0, 7'b0000000, 2'b00};
        vecs[7]  = '{1'b0, 1'b0, 7'd0,   1'b0, 1'b0, 0,  1'b0, 1'b0, 7'b0000000, 2'b00};
        vecs[8]  = '{1'b0, 1'b0, 7'd0,   1'b0, 1'b0, 0,  1'b0, 1'b0, 7'b0000000, 2'b00};
        vecs[9]  = '{1'b0, 1'b1, 7'd120, 1'b0, 1'b0, 99, 1'b1, 1'b0, 7'b0111111, 2'b01};
        vecs[10] = '{1'b0, 1'b0, 7'd0,   1'b0, 1'b0, 99, 1'b1, 1'b0, 7'b1101111, 2'b01};
        vecs[11] = '{1'b0, 1'b0, 7'd0,   1'b0, 1'b0, 99, 1'b1, 1'b0, 7'b1101111, 2'b01};
        vecs[12] = '{1'b0, 1'b0, 7'd0,   1'b0, 1'b0, 99, 1'b1, 1'b0, 7'b1101111, 2'b01};
        vecs[13] = '{1'b0, 1'b0, 7'd0,   1'b0, 1'b0, 99, 1'b1, 1'b0, 7'b1101111, 2'b10};
        vecs[14] = '{1'b0, 1'b0, 7'd0,   1'b0, 1'b0, 99, 1'b1, 1'b0, 7'b1101111, 2'b10};
        vecs[15] = '{1'b0, 1'b0, 7'd0,   1'b0, 1'b0, 99, 1'b1, 1'b0, 7'b1101111, 2'b10};
        vecs[16] = '{1'b0, 1'b0, 7'd0,   1'b0, 1'b0, 99, 1'b1, 1'b0, 7'b1101111, 2'b10};
        vecs[17] = '{1'b0, 1'b0, 7'd0,   1'b0, 1'b0, 98, 1'b1, 1'b0, 7'b1101111, 2'b01};
        vecs[18] = '{1'b0, 1'b0, 7'd0,   1'b0, 1'b0, 98, 1'b1, 1'b0, 7'b1111111, 2'b01};
        vecs[19] = '{1'b0, 1'b0, 7'd0,   1'b0, 1'b1, 98, 1'b1, 1'b0, 7'b0000000, 2'b00};
        vecs[20] = '{1'b1, 1'b0, 7'd0,   1'b0, 1'b1, 0,  1'b0, 1'b0, 7'b0000000, 2'b00};
        vecs[21] = '{1'b0, 1'b0, 7'd0,   1'b0, 1'b0, 0,  1'b0, 1'b0, 7'b0111111, 2'b01};

        // Table-driven vectors
        for (int i = 0; i < 22; i++) begin
            rst = vecs[i].rst; load = vecs[i].load; load_val = vecs[i].lv;
            pause = vecs[i].pause; blank = vecs[i].blank;
            step();
            check($sformatf("vec%0d.count", i),   count,   vecs[i].e_count);
            check($sformatf("vec%0d.busy", i),    busy,    vecs[i].e_busy);
            check($sformatf("vec%0d.done", i),    done,    vecs[i].e_done);
            check($sformatf("vec%0d.seg", i),     seg,     vecs[i].e_seg);
            check($sformatf("vec%0d.dig_sel", i), dig_sel, vecs[i].e_dsel);
        end

        // Countdown from 3 to 0 with a single done pulse
        rst = 1'b1; step(); rst = 1'b0;
        load = 1'b1; load_val = 7'd3; cycle("cd3_load"); load = 1'b0;
        check("cd3_busy", busy, 1'b1);
        done_seen = 0;
        for (int i = 1; i <= 23; i++) begin
            cycle("cd3");
            if (done) done_seen++;
        end
        check("cd3_early_done", done_seen, 0);
        check("cd3_count_e23", count, 7'd1);
        cycle("cd3_zero");
        check("cd3_count_zero", count, 7'd0);
        check("cd3_done_pulse", done, 1'b1);
        check("cd3_busy_zero", busy, 1'b0);
        cycle("cd3_after");
        check("cd3_done_one_cycle", done, 1'b0);

        // Pause holds the count; counting resumes from the held phase
        load = 1'b1; load_val = 7'd5; cycle("pz_load"); load = 1'b0;
        for (int i = 1; i <= 3; i++) cycle("pz_run");
        pause = 1'b1;
        for (int i = 4; i <= 23; i++) begin
            cycle("pz_hold");
            check("pz_hold_count", count, 7'd5);
        end
        pause = 1'b0;
        for (int i = 24; i <= 28; i++) cycle("pz_resume");
        check("pz_count_before", count, 7'd5);
        cycle("pz_dec");
        check("pz_count_dec", count, 7'd4);

        // Load in the very cycle the count would expire
        load = 1'b1; load_val = 7'd1; cycle("lx_load1"); load = 1'b0;
        for (int i = 1; i <= 7; i++) cycle("lx_run");
        load = 1'b1; load_val = 7'd4; cycle("lx_load4"); load = 1'b0;
        check("lx_count", count, 7'd4);
        check("lx_no_done", done, 1'b0);
        check("lx_busy", busy, 1'b1);
        cycle("lx_next");
        check("lx_no_done_next", done, 1'b0);

        // Blank mid-run, then reset mid-run
        load = 1'b1; load_val = 7'd9; cycle("bk_load"); load = 1'b0;
        for (int i = 1; i <= 3; i++) cycle("bk_run");
        blank = 1'b1; cycle("bk_on");
        check("bk_seg", seg, 7'b0);
        check("bk_dig_sel", dig_sel, 2'b00);
        for (int i = 5; i <= 10; i++) cycle("bk_run");
        check("bk_counts_on", count, 7'd8);
        blank = 1'b0;
        rst = 1'b1; cycle("rs_mid"); rst = 1'b0;
        check("rs_count", count, 7'd0);
        check("rs_busy", busy, 1'b0);
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            cycle("rs_after");
            if (done) done_seen++;
        end
        check("rs_no_done", done_seen, 0);

        // Randomized run against the model
        for (int i = 0; i < 4000; i++) begin
            rst  = ($urandom_range(0, 499) == 0);
            load = ($urandom_range(0, 29) == 0);
            load_val = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                                   : 7'($urandom_range(0, 5));
            if ($urandom_range(0, 11) == 0) pause = ~pause;
            if ($urandom_range(0, 14) == 0) blank = ~blank;
            cycle("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/countdown_display_ctrl.md
COUNTDOWN_DISPLAY_CTRL -- requirements
Module: countdown_display_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000000, clk cycles per countdown second (>=2).
REQ-002 Parameter SCAN_DIV, default 50000, clk cycles each digit is driven per scan slot (>=2).
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 load  input  1  one-cycle strobe; captures load_val as new count.
REQ-006 load_val  input  7  countdown start value, binary seconds.
REQ-007 pause  input  1  level; freezes countdown while high.
REQ-008 blank  input  1  level; forces display dark.
REQ-009 count  output  7  current remaining seconds, registered.
REQ-010 busy  output  1  high in RUN or HOLD.
REQ-011 done  output  1  one-cycle pulse when count reaches 0 by countdown.
REQ-012 seg  output  7  active-high segments, bit0=a ... bit6=g, registered.
REQ-013 dig_sel  output  2  one-hot active-high digit enable: 01 ones, 10 tens, 00 dark; registered.

Function
REQ-014 States: IDLE, RUN, HOLD.
REQ-015 load, any state: count <= min(load_val, 99); tick counter <= 0; next state IDLE if value 0, else HOLD if pause=1, else RUN; no done pulse.
REQ-016 load has priority over tick expiry and pause transitions in the same cycle.
REQ-017 RUN: tick counter increments each cycle; on reaching TICK_DIV-1 it wraps to 0 and count decrements.
REQ-018 RUN with count==1 at tick wrap: count <= 0, state <= IDLE, done=1 on the next cycle for exactly one cycle.
REQ-019 RUN with pause=1 (no load): state <= HOLD; tick counter holds value.
REQ-020 HOLD with pause=0: state <= RUN; tick counter resumes from held value.
REQ-021 IDLE: count and tick counter hold; pause ignored.
REQ-022 Digit split: tens = count/10, ones = count%10, combinational, 4 bits each, both 0..9.
REQ-023 Scan counter counts 0..SCAN_DIV-1 continuously in all states; at wrap, digit index toggles ones<->tens.
REQ-024 Shared decoder input: ones in ones slot, tens in tens slot; one decoder instance.
REQ-025 Decoder map 0..9: 0111111, 0000110, 1011011, 1001111, 1100110, 1101101, 1111101, 0000111, 1111111, 1101111.
REQ-026 Leading-zero blanking: in tens slot with tens==0, seg=0000000 and dig_sel=00.
REQ-027 blank=1: seg=0000000, dig_sel=00 on next cycle; scan counter keeps running.
REQ-028 seg/dig_sel registered: one-cycle latency from scan slot change, count change, or blank change.
REQ-029 Scan and countdown are independent; count change mid-slot updates seg on the next cycle.

Reset
REQ-030 rst=1 at a clock edge: state IDLE, count 0, tick and scan counters 0, digit index ones, done 0, busy 0, seg 0000000, dig_sel 00.
REQ-031 First cycle after reset release: seg=0111111, dig_sel=01.
REQ-032 rst overrides load, pause and blank; reset mid-RUN aborts without done pulse.

Structure
REQ-033 Shared package holds state encoding (IDLE/RUN/HOLD), MAX_COUNT=99, and the 7-bit blank pattern constant.
REQ-034 Decoder is a sub-module, bin_to_7seg (4-bit in, 7-bit active-high out), instantiated once.

Verification (TICK_DIV=8, SCAN_DIV=4)
REQ-035 Reset, then idle 16 cycles -> dig_sel alternates 01/00 every 4 cycles, seg 0111111 in ones slots, busy 0.
REQ-036 load with load_val=3 -> busy 1; count 3->2->1->0 at 8-cycle intervals; done high one cycle after 0; busy 0; tens slots dark.
REQ-037 load_val=120 -> count 99; tens slot seg 1101111 with dig_sel 10; ones slot seg 1101111 with dig_sel 01.
REQ-038 load_val=5, pause high for 20 cycles after 3 cycles -> count stays 5 during pause; decrements 5 cycles after release.
REQ-039 load in the cycle count would reach 0 (count=1, tick=7), load_val=4 -> count 4, no done pulse, stays RUN.
REQ-040 blank=1 mid-RUN -> seg 0000000, dig_sel 00 next cycle; countdown continues; rst mid-RUN -> count 0, no done.
